// File: rtl/aes_key_sched_seq.sv
// Sequential AES-128/192/256 key expander: one schedule word per clock into a
// 60-word store, round keys served through a registered read port.
// Optional build macro: AES_KS_REVERSE_EN adds i_rk_rev for reversed round-key indexing.
module aes_key_sched_seq #(
  parameter int MAX_NK = 8,
  parameter int MAX_NR = 14
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [1:0]            i_key_len,
  input  logic [32*MAX_NK-1:0]  i_key_in,
`ifdef AES_KS_REVERSE_EN
  input  logic                  i_rk_rev,
`endif
  input  logic [3:0]            i_rk_idx,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  output logic                  o_rk_valid,
  output logic [3:0]            o_nr_out,
  output logic [127:0]          o_rk_out,
  output logic [1:0]            o_dbg_state
);

  localparam int NW = 4 * (MAX_NR + 1);
  localparam int IW = $clog2(NW + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXPAND, S_FIN} state_t;

  state_t               r_state, w_next;
  logic [32*MAX_NK-1:0] r_key;
  logic [3:0]           r_nk, r_nr, r_nr_out;
  logic [IW-1:0]        r_i;
  logic [2:0]           r_kc;
  logic [7:0]           r_rcon;
  logic [31:0]          r_w [0:NW-1];
  logic                 r_done, r_err, r_rk_valid;
  logic [127:0]         r_rk_out;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x12, t, inv;
    x2  = gf_mul(x, x);
    x3  = gf_mul(x2, x);
    t   = gf_mul(x3, x3);
    x12 = gf_mul(t, t);
    t   = gf_mul(x12, x3);
    t   = gf_mul(t, t);
    t   = gf_mul(t, t);
    t   = gf_mul(t, t);
    t   = gf_mul(t, t);
    t   = gf_mul(t, x12);
    inv = gf_mul(t, x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic          w_idle, w_accept, w_last;
  logic [31:0]   w_prev, w_sub_in, w_sub, w_temp, w_new;
  logic [3:0]    w_ridx;
  logic [IW-1:0] w_base;
  logic          w_rd_ok;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = w_idle && i_start && (i_key_len != 2'd3);
  assign w_last   = (r_i == (IW'({r_nr, 2'b00}) + IW'(3)));

  assign w_prev   = r_w[r_i - IW'(1)];
  assign w_sub_in = (r_kc == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;
  assign w_sub    = {sbox(w_sub_in[31:24]), sbox(w_sub_in[23:16]),
                     sbox(w_sub_in[15:8]),  sbox(w_sub_in[7:0])};
  assign w_temp   = (r_kc == 3'd0)                    ? (w_sub ^ {r_rcon, 24'h0}) :
                    ((r_nk == 4'd8) && (r_kc == 3'd4)) ? w_sub : w_prev;
  assign w_new    = r_w[r_i - IW'(r_nk)] ^ w_temp;

`ifdef AES_KS_REVERSE_EN
  assign w_ridx = i_rk_rev ? (r_nr_out - i_rk_idx) : i_rk_idx;
`else
  assign w_ridx = i_rk_idx;
`endif
  assign w_base  = IW'({w_ridx, 2'b00});
  assign w_rd_ok = r_rk_valid && (i_rk_idx <= r_nr_out);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOAD;
      S_LOAD:   w_next = S_EXPAND;
      S_EXPAND: if (w_last) w_next = S_FIN;
      S_FIN:    w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_key      <= '0;
      r_nk       <= 4'd0;
      r_nr       <= 4'd0;
      r_i        <= '0;
      r_kc       <= 3'd0;
      r_rcon     <= 8'h00;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_rk_valid <= 1'b0;
      r_nr_out   <= 4'd0;
      r_rk_out   <= '0;
    end else begin
      r_state  <= w_next;
      r_done   <= (r_state == S_FIN);
      r_err    <= w_idle && i_start && (i_key_len == 2'd3);
      r_rk_out <= w_rd_ok ? {r_w[w_base], r_w[w_base + IW'(1)],
                             r_w[w_base + IW'(2)], r_w[w_base + IW'(3)]} : 128'h0;
      if (w_idle && i_start) r_rk_valid <= 1'b0;
      else if (r_state == S_FIN) r_rk_valid <= 1'b1;
      if (r_state == S_FIN) r_nr_out <= r_nr;
      if (w_accept) begin
        r_key <= i_key_in;
        r_nk  <= 4'd4 + {1'b0, i_key_len, 1'b0};
        r_nr  <= 4'd10 + {1'b0, i_key_len, 1'b0};
      end
      if (r_state == S_LOAD) begin
        r_i    <= IW'(r_nk);
        r_kc   <= 3'd0;
        r_rcon <= 8'h01;
      end
      if (r_state == S_EXPAND) begin
        r_i  <= r_i + IW'(1);
        r_kc <= (r_kc == 3'(r_nk - 4'd1)) ? 3'd0 : r_kc + 3'd1;
        if (r_kc == 3'd0) r_rcon <= {r_rcon[6:0], 1'b0} ^ (r_rcon[7] ? 8'h1b : 8'h00);
      end
    end
  end

  // Store is not reset; every word is rewritten before any read of it in a run.
  always_ff @(posedge i_clk) begin
    if (r_state == S_LOAD) begin
      for (int j = 0; j < MAX_NK; j++)
        r_w[IW'(j)] <= r_key[32*(MAX_NK-j)-1 -: 32];
    end else if (r_state == S_EXPAND) begin
      r_w[r_i] <= w_new;
    end
  end

  assign o_busy      = (r_state == S_LOAD) || (r_state == S_EXPAND);
  assign o_done      = r_done;
  assign o_err       = r_err;
  assign o_rk_valid  = r_rk_valid;
  assign o_nr_out    = r_nr_out;
  assign o_rk_out    = r_rk_out;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_key_sched_seq.sv
// Directed bench for aes_key_sched_seq using FIPS-197 expansion vectors.
module tb_aes_key_sched_seq;

  logic         clk = 1'b0;
  logic         rst, start, rk_rev;
  logic [1:0]   key_len;
  logic [255:0] key_in;
  logic [3:0]   rk_idx;
  logic         busy, done, err, rk_valid;
  logic [3:0]   nr_out;
  logic [127:0] rk_out;
  logic [1:0]   dbg_state;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  always #5 clk = ~clk;

  aes_key_sched_seq #(.MAX_NK(8), .MAX_NR(14)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_key_len(key_len), .i_key_in(key_in),
`ifdef AES_KS_REVERSE_EN
    .i_rk_rev(rk_rev),
`endif
    .i_rk_idx(rk_idx), .o_busy(busy), .o_done(done), .o_err(err), .o_rk_valid(rk_valid),
    .o_nr_out(nr_out), .o_rk_out(rk_out), .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts a run and waits (bounded) for done; optionally re-pulses start mid-run.
  task automatic run_key(input string tag, input logic [1:0] len, input logic [255:0] key,
                         input bit glitch, input int exp_lat, input logic [3:0] exp_nr);
    int cyc;
    @(negedge clk);
    key_len = len; key_in = key; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) check({tag, " busy"}, 128'(busy), 128'd1);
      if (glitch && cyc == 10) begin start = 1'b1; key_len = 2'd2; key_in = ~key; end
      if (glitch && cyc == 11) start = 1'b0;
      if (done) break;
    end
    check({tag, " latency"}, 128'(cyc), 128'(exp_lat));
    check({tag, " rk_valid"}, 128'(rk_valid), 128'd1);
    check({tag, " nr_out"}, 128'(nr_out), 128'(exp_nr));
    @(posedge clk); #1;
    check({tag, " done pulse"}, 128'(done), 128'd0);
  endtask

  task automatic read_rk(input string tag, input logic [3:0] idx, input logic rev,
                         input logic [127:0] exp);
    @(negedge clk);
    rk_idx = idx; rk_rev = rev;
    @(posedge clk); #1;
    check(tag, rk_out, exp);
  endtask

  initial begin
    int dones;
    rst = 1'b1; start = 1'b0; rk_rev = 1'b0; key_len = 2'd0; key_in = '0; rk_idx = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 128'(busy), 128'd0);
    check("rst done", 128'(done), 128'd0);
    check("rst err", 128'(err), 128'd0);
    check("rst rk_valid", 128'(rk_valid), 128'd0);
    check("rst nr_out", 128'(nr_out), 128'd0);
    check("rst rk_out", rk_out, 128'd0);
    check("rst state", 128'(dbg_state), 128'd0);
    @(negedge clk); rst = 1'b0;

    run_key("aes128", 2'd0, K128, 1'b0, 42, 4'd10);
    read_rk("aes128 rk0", 4'd0, 1'b0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_rk("aes128 rk1", 4'd1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk("aes128 rk2", 4'd2, 1'b0, 128'hf2c295f27a96b9435935807a7359f67f);
    read_rk("aes128 rk10", 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk("aes128 rk11", 4'd11, 1'b0, 128'h0);

    run_key("aes192", 2'd1, K192, 1'b0, 48, 4'd12);
    read_rk("aes192 rk0", 4'd0, 1'b0, 128'h8e73b0f7da0e6452c810f32b809079e5);
    read_rk("aes192 rk1", 4'd1, 1'b0, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
    read_rk("aes192 rk12", 4'd12, 1'b0, 128'he98ba06f448c773c8ecc720401002202);
    read_rk("aes192 rk13", 4'd13, 1'b0, 128'h0);

    run_key("aes256", 2'd2, K256, 1'b0, 54, 4'd14);
    read_rk("aes256 rk1", 4'd1, 1'b0, 128'h1f352c073b6108d72d9810a30914dff4);
    read_rk("aes256 rk2", 4'd2, 1'b0, 128'h9ba354118e6925afa51a8b5f2067fcde);
    read_rk("aes256 rk14", 4'd14, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e);
    read_rk("aes256 rk15", 4'd15, 1'b0, 128'h0);

    run_key("glitch", 2'd0, K128, 1'b1, 42, 4'd10);
    read_rk("glitch rk1", 4'd1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk("glitch rk10", 4'd10, 1'b0, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset in the middle of an expansion.
    @(negedge clk);
    key_len = 2'd2; key_in = K256; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort busy", 128'(busy), 128'd0);
    check("abort rk_valid", 128'(rk_valid), 128'd0);
    check("abort nr_out", 128'(nr_out), 128'd0);
    dones = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort no done", 128'(dones), 128'd0);
    run_key("restart", 2'd0, K128, 1'b0, 42, 4'd10);
    read_rk("restart rk1", 4'd1, 1'b0, 128'ha0fafe1788542cb123a339392a6c7605);

    // Reserved key length.
    @(negedge clk);
    key_len = 2'd3; key_in = K128; start = 1'b1; rk_idx = 4'd0;
    @(posedge clk); #1;
    start = 1'b0;
    check("err pulse", 128'(err), 128'd1);
    check("err no done", 128'(done), 128'd0);
    check("err rk_valid", 128'(rk_valid), 128'd0);
    check("err busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    check("err one cycle", 128'(err), 128'd0);
    check("err rk_out zero", rk_out, 128'h0);

`ifdef AES_KS_REVERSE_EN
    run_key("rev128", 2'd0, K128, 1'b0, 42, 4'd10);
    read_rk("rev rk0", 4'd0, 1'b1, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk("rev rk10", 4'd10, 1'b1, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_rk("rev rk9", 4'd9, 1'b1, 128'ha0fafe1788542cb123a339392a6c7605);
    read_rk("rev rk11", 4'd11, 1'b1, 128'h0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
